// File: rtl/reg_wb_if.sv
// Writeback arbiter bus: two writeback requesters, register-file write port,
// issue-side scoreboard set port and decode-side hazard check.
interface reg_wb_if #(
    parameter int unsigned TAM = 16
);
    logic           alu_req;
    logic           alu_ack;
    logic [3:0]     alu_rd;
    logic [TAM-1:0] alu_data;
    logic           mem_req;
    logic           mem_ack;
    logic [3:0]     mem_rd;
    logic [TAM-1:0] mem_data;
    logic [TAM-1:0] RD;
    logic [3:0]     CORE_REG_RD;
    logic           write;
    logic           issue_valid;
    logic [3:0]     issue_rd;
    logic [3:0]     chk_rf1;
    logic [3:0]     chk_rf2;
    logic [3:0]     chk_rd;
    logic           stall;
    logic [15:0]    busy;

    modport master (
        output alu_req, alu_rd, alu_data, mem_req, mem_rd, mem_data,
               issue_valid, issue_rd, chk_rf1, chk_rf2, chk_rd,
        input  alu_ack, mem_ack, RD, CORE_REG_RD, write, stall, busy
    );

    modport slave (
        input  alu_req, alu_rd, alu_data, mem_req, mem_rd, mem_data,
               issue_valid, issue_rd, chk_rf1, chk_rf2, chk_rd,
        output alu_ack, mem_ack, RD, CORE_REG_RD, write, stall, busy
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter (ALU vs. load) with pending-write scoreboard.
// Define REG_WB_ARB_RR_EN for round-robin arbitration; default is mem-first priority.
module reg_wb_arbiter #(
    parameter int unsigned TAM = 16
) (
    input logic      clk,
    input logic      rst,
    reg_wb_if.slave  bus
);
    localparam int unsigned IDX_W = 4;
    localparam int unsigned NREG  = 16;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

    state_t           state_q, state_d;
    logic [TAM-1:0]   data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             win_mem_q, win_mem_d;
    logic             write_q, write_d;
    logic             alu_ack_q, alu_ack_d;
    logic             mem_ack_q, mem_ack_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic             grant_mem;

`ifdef REG_WB_ARB_RR_EN
    // ptr_q=0 favours ALU, 1 favours mem; only consulted when both request
    logic ptr_q, ptr_d;

    assign grant_mem = bus.mem_req & (~bus.alu_req | ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && (bus.alu_req || bus.mem_req)) begin
            ptr_d = ~grant_mem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign grant_mem = bus.mem_req;
`endif

    // Transaction FSM: latch winner on grant, strobe and ack one cycle after setup
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        idx_d     = idx_q;
        win_mem_d = win_mem_q;
        write_d   = 1'b0;
        alu_ack_d = 1'b0;
        mem_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.alu_req || bus.mem_req) begin
                    state_d   = SETUP;
                    win_mem_d = grant_mem;
                    idx_d     = grant_mem ? bus.mem_rd : bus.alu_rd;
                    data_d    = grant_mem ? bus.mem_data : bus.alu_data;
                end
            end
            SETUP: begin
                state_d   = STROBE;
                write_d   = (idx_q != IDX_W'(0));
                alu_ack_d = ~win_mem_q;
                mem_ack_d = win_mem_q;
            end
            STROBE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Scoreboard: clear on the edge ending STROBE, a same-edge set wins
    always_comb begin
        busy_d = busy_q;
        if (state_q == STROBE) begin
            busy_d[idx_q] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != IDX_W'(0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            idx_q     <= '0;
            win_mem_q <= 1'b0;
            write_q   <= 1'b0;
            alu_ack_q <= 1'b0;
            mem_ack_q <= 1'b0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            win_mem_q <= win_mem_d;
            write_q   <= write_d;
            alu_ack_q <= alu_ack_d;
            mem_ack_q <= mem_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.RD          = data_q;
    assign bus.CORE_REG_RD = idx_q;
    assign bus.write       = write_q;
    assign bus.alu_ack     = alu_ack_q;
    assign bus.mem_ack     = mem_ack_q;
    assign bus.busy        = busy_q;
    assign bus.stall       = busy_q[bus.chk_rf1] | busy_q[bus.chk_rf2] | busy_q[bus.chk_rd];
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model (grant times, winner rule, scoreboard set/clear).
module tb_reg_wb_arbiter;
    localparam int unsigned TAM = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_wb_if #(.TAM(TAM)) bus ();

    reg_wb_arbiter #(.TAM(TAM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic zero_inputs();
        bus.alu_req = 1'b0; bus.alu_rd = 4'd0; bus.alu_data = '0;
        bus.mem_req = 1'b0; bus.mem_rd = 4'd0; bus.mem_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = 4'd0;
        bus.chk_rf1 = 4'd0; bus.chk_rf2 = 4'd0; bus.chk_rd = 4'd0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // rst must beat requests and issue on the same edge
        bus.alu_req = 1'b1; bus.alu_rd = 4'd2; bus.alu_data = 16'h1111;
        bus.mem_req = 1'b1; bus.mem_rd = 4'd3; bus.mem_data = 16'h2222;
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd3; bus.chk_rf1 = 4'd3;
        rst = 1'b1;
        tick();
        total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", bus.write); end
        total++; if (bus.alu_ack !== 1'b0) begin bad++; $display("FAIL reset_alu_ack got=%b exp=0", bus.alu_ack); end
        total++; if (bus.mem_ack !== 1'b0) begin bad++; $display("FAIL reset_mem_ack got=%b exp=0", bus.mem_ack); end
        total++; if (bus.busy !== 16'h0000) begin bad++; $display("FAIL reset_busy got=%h exp=0000", bus.busy); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        total++; if (bus.CORE_REG_RD !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus.CORE_REG_RD); end
        total++; if (bus.RD !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", bus.RD); end
        zero_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_alu();
        do_reset();
        bus.alu_req = 1'b1; bus.alu_rd = 4'd5; bus.alu_data = 16'hBEEF;
        tick();
        total++; if (bus.CORE_REG_RD !== 4'd5) begin bad++; $display("FAIL alu_setup_idx got=%0d exp=5", bus.CORE_REG_RD); end
        total++; if (bus.RD !== 16'hBEEF) begin bad++; $display("FAIL alu_setup_data got=%h exp=beef", bus.RD); end
        total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL alu_setup_write got=%b exp=0", bus.write); end
        total++; if (bus.alu_ack !== 1'b0) begin bad++; $display("FAIL alu_setup_ack got=%b exp=0", bus.alu_ack); end
        tick();
        total++; if (bus.write !== 1'b1) begin bad++; $display("FAIL alu_strobe_write got=%b exp=1", bus.write); end
        total++; if (bus.alu_ack !== 1'b1) begin bad++; $display("FAIL alu_strobe_ack got=%b exp=1", bus.alu_ack); end
        total++; if (bus.mem_ack !== 1'b0) begin bad++; $display("FAIL alu_strobe_mem_ack got=%b exp=0", bus.mem_ack); end
        total++; if (bus.CORE_REG_RD !== 4'd5 || bus.RD !== 16'hBEEF) begin bad++; $display("FAIL alu_strobe_hold got=%0d/%h exp=5/beef", bus.CORE_REG_RD, bus.RD); end
        bus.alu_req = 1'b0;
        tick();
        total++; if (bus.write !== 1'b0 || bus.alu_ack !== 1'b0) begin bad++; $display("FAIL alu_idle write/ack got=%b/%b exp=0/0", bus.write, bus.alu_ack); end
    endtask

    task automatic test_both_requesters();
        int n;
        int who [2];
        int when [2];
        int idx [2];
        int exp_first;
        do_reset();
        bus.alu_req = 1'b1; bus.alu_rd = 4'd9; bus.alu_data = 16'h5A5A;
        bus.mem_req = 1'b1; bus.mem_rd = 4'd3; bus.mem_data = 16'h1234;
        n = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.alu_ack === 1'b1 && n < 2) begin
                who[n] = 0; when[n] = c; idx[n] = int'(bus.CORE_REG_RD); n++;
                bus.alu_req = 1'b0;
            end
            if (bus.mem_ack === 1'b1 && n < 2) begin
                who[n] = 1; when[n] = c; idx[n] = int'(bus.CORE_REG_RD); n++;
                bus.mem_req = 1'b0;
            end
        end
`ifdef REG_WB_ARB_RR_EN
        exp_first = 0;
`else
        exp_first = 1;
`endif
        total++; if (n != 2) begin bad++; $display("FAIL both_ack_count got=%0d exp=2", n); end
        if (n == 2) begin
            total++; if (who[0] != exp_first) begin bad++; $display("FAIL both_first_winner got=%0d exp=%0d (0=alu 1=mem)", who[0], exp_first); end
            total++; if (who[1] != 1 - exp_first) begin bad++; $display("FAIL both_second_winner got=%0d exp=%0d", who[1], 1 - exp_first); end
            total++; if (when[0] != 2) begin bad++; $display("FAIL both_first_time got=%0d exp=2", when[0]); end
            total++; if (when[1] != 5) begin bad++; $display("FAIL both_second_time got=%0d exp=5", when[1]); end
            total++; if (idx[0] != (exp_first == 1 ? 3 : 9)) begin bad++; $display("FAIL both_first_idx got=%0d exp=%0d", idx[0], (exp_first == 1 ? 3 : 9)); end
        end
        zero_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd7; bus.chk_rf1 = 4'd7;
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.busy !== 16'h0080) begin bad++; $display("FAIL sb_set_busy got=%h exp=0080", bus.busy); end
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL sb_set_stall got=%b exp=1", bus.stall); end
        bus.alu_req = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 16'hCAFE;
        tick();
        tick();
        total++; if (bus.alu_ack !== 1'b1) begin bad++; $display("FAIL sb_ack got=%b exp=1", bus.alu_ack); end
        bus.alu_req = 1'b0;
        tick();
        total++; if (bus.busy !== 16'h0000) begin bad++; $display("FAIL sb_clear_busy got=%h exp=0000", bus.busy); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL sb_clear_stall got=%b exp=0", bus.stall); end
        // set and clear of index 7 on the same edge: set must win
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd7;
        bus.alu_req = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 16'h0707;
        tick();
        bus.issue_valid = 1'b0;
        tick();
        total++; if (bus.alu_ack !== 1'b1) begin bad++; $display("FAIL sb_race_ack got=%b exp=1", bus.alu_ack); end
        bus.alu_req = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd7; bus.chk_rf1 = 4'd0; bus.chk_rf2 = 4'd7;
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.busy !== 16'h0080) begin bad++; $display("FAIL sb_race_busy got=%h exp=0080", bus.busy); end
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL sb_race_stall got=%b exp=1", bus.stall); end
    endtask

    task automatic test_rd_zero();
        int wrote;
        do_reset();
        bus.mem_req = 1'b1; bus.mem_rd = 4'd0; bus.mem_data = 16'hFFFF;
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd0;
        wrote = 0;
        tick();
        if (bus.write === 1'b1) wrote++;
        tick();
        if (bus.write === 1'b1) wrote++;
        total++; if (bus.mem_ack !== 1'b1) begin bad++; $display("FAIL rd0_ack got=%b exp=1", bus.mem_ack); end
        bus.mem_req = 1'b0; bus.issue_valid = 1'b0;
        tick();
        if (bus.write === 1'b1) wrote++;
        total++; if (wrote != 0) begin bad++; $display("FAIL rd0_write strobes got=%0d exp=0", wrote); end
        total++; if (bus.busy !== 16'h0000) begin bad++; $display("FAIL rd0_busy got=%h exp=0000", bus.busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.alu_req = 1'b1; bus.alu_rd = 4'd4; bus.alu_data = 16'h4444;
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd4;
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.busy !== 16'h0010) begin bad++; $display("FAIL mid_busy_pre got=%h exp=0010", bus.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.write !== 1'b0 || bus.alu_ack !== 1'b0) begin bad++; $display("FAIL mid_rst write/ack got=%b/%b exp=0/0", bus.write, bus.alu_ack); end
        total++; if (bus.busy !== 16'h0000) begin bad++; $display("FAIL mid_rst_busy got=%h exp=0000", bus.busy); end
        tick();
        total++; if (bus.CORE_REG_RD !== 4'd4 || bus.write !== 1'b0) begin bad++; $display("FAIL mid_regrant_setup got=%0d/%b exp=4/0", bus.CORE_REG_RD, bus.write); end
        tick();
        total++; if (bus.write !== 1'b1 || bus.alu_ack !== 1'b1) begin bad++; $display("FAIL mid_regrant_strobe write/ack got=%b/%b exp=1/1", bus.write, bus.alu_ack); end
        bus.alu_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [15:0]    busy_m;
        bit             a_pend, m_pend, active, g_mem, ptr_mem;
        logic [3:0]     a_rd, m_rd, g_rd;
        logic [TAM-1:0] a_dat, m_dat, g_dat;
        int             e, g, next_free;
        bit             e_wr, e_aack, e_mack, e_stall;
        do_reset();
        busy_m = '0; a_pend = 0; m_pend = 0; active = 0; ptr_mem = 0;
        g_mem = 0; g_rd = '0; g_dat = '0; a_rd = '0; m_rd = '0; a_dat = '0; m_dat = '0;
        e = 0; g = 0; next_free = 0;
        for (int k = 0; k < 800; k++) begin
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1; a_rd = 4'($urandom_range(0, 15)); a_dat = TAM'($urandom);
            end
            if (!m_pend && $urandom_range(0, 2) == 0) begin
                m_pend = 1; m_rd = 4'($urandom_range(0, 15)); m_dat = TAM'($urandom);
            end
            bus.alu_req = a_pend; bus.alu_rd = a_rd; bus.alu_data = a_dat;
            bus.mem_req = m_pend; bus.mem_rd = m_rd; bus.mem_data = m_dat;
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_rd = (active && $urandom_range(0, 1) == 0) ? g_rd : 4'($urandom_range(0, 15));
            bus.chk_rf1 = 4'($urandom_range(0, 15));
            bus.chk_rf2 = 4'($urandom_range(0, 15));
            bus.chk_rd  = 4'($urandom_range(0, 15));
            @(posedge clk);
            e++;
            // model of this edge: finished write frees its index, issue marks one, then arbitration
            if (active && e == g + 2) begin
                busy_m[g_rd] = 1'b0;
                active = 0;
            end
            if (bus.issue_valid && bus.issue_rd != 4'd0) busy_m[bus.issue_rd] = 1'b1;
            if (!active && e >= next_free && (a_pend || m_pend)) begin
`ifdef REG_WB_ARB_RR_EN
                g_mem = m_pend && (!a_pend || ptr_mem);
                ptr_mem = !g_mem;
`else
                g_mem = m_pend;
`endif
                g_rd = g_mem ? m_rd : a_rd;
                g_dat = g_mem ? m_dat : a_dat;
                g = e; active = 1; next_free = e + 3;
            end
            busy_m[0] = 1'b0;
            e_wr    = active && e == g + 1 && g_rd != 4'd0;
            e_aack  = active && e == g + 1 && !g_mem;
            e_mack  = active && e == g + 1 && g_mem;
            e_stall = (bus.chk_rf1 != 4'd0 && busy_m[bus.chk_rf1]) ||
                      (bus.chk_rf2 != 4'd0 && busy_m[bus.chk_rf2]) ||
                      (bus.chk_rd  != 4'd0 && busy_m[bus.chk_rd]);
            @(negedge clk);
            total++; if (bus.write !== e_wr) begin bad++; $display("FAIL rnd_write cyc=%0d got=%b exp=%b", e, bus.write, e_wr); end
            total++; if (bus.alu_ack !== e_aack) begin bad++; $display("FAIL rnd_alu_ack cyc=%0d got=%b exp=%b", e, bus.alu_ack, e_aack); end
            total++; if (bus.mem_ack !== e_mack) begin bad++; $display("FAIL rnd_mem_ack cyc=%0d got=%b exp=%b", e, bus.mem_ack, e_mack); end
            total++; if (bus.busy !== busy_m) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", e, bus.busy, busy_m); end
            total++; if (bus.stall !== e_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", e, bus.stall, e_stall); end
            if (active && (e == g || e == g + 1)) begin
                total++;
                if (bus.CORE_REG_RD !== g_rd || bus.RD !== g_dat) begin
                    bad++; $display("FAIL rnd_payload cyc=%0d got=%0d/%h exp=%0d/%h", e, bus.CORE_REG_RD, bus.RD, g_rd, g_dat);
                end
            end
            if (e_aack) a_pend = 0;
            if (e_mack) m_pend = 0;
        end
        zero_inputs();
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        zero_inputs();
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_both_requesters();
        test_scoreboard();
        test_rd_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
